dcache_port_arbiter: RTL and testbench

Shares one data-cache request port between the scalar load unit and the vector load/store unit (RVV builds). The block arbitrates requests and holds the selection stable until the cache grants it. It tags each request with its owner, tracks outstanding transactions per requester, and routes registered responses back to the owner. It sits between the two load paths and a single write-through dcache port.

---
 rtl/dcache_arb_pkg.sv | 31 +++
 rtl/dcache_arb_out_cnt.sv | 44 ++++
 rtl/dcache_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_arb_pkg.sv
// Shared types for the dcache port arbiter: FSM states, owner encoding and request payload layout.
package dcache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_S = 2'd1,
    LOCK_V = 2'd2
  } arb_state_e;

  localparam logic OWNER_SCALAR = 1'b0;
  localparam logic OWNER_VECTOR = 1'b1;

  localparam int ADDR_W  = 64;
  localparam int BE_W    = 8;
  localparam int SIZE_W  = 4;
  localparam int WDATA_W = 64;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [BE_W-1:0]    be;
    logic [SIZE_W-1:0]  size;
    logic [WDATA_W-1:0] wdata;
  } dcache_arb_req_t;

  localparam int REQ_W = $bits(dcache_arb_req_t);

  function automatic arb_state_e lock_state(input logic owner);
    return (owner == OWNER_VECTOR) ? LOCK_V : LOCK_S;
  endfunction

endpackage

// File: rtl/dcache_arb_out_cnt.sv
// Outstanding-transaction counter for one requester; eligible while its request is up and the count is below MaxOut.
module dcache_arb_out_cnt #(
  parameter int MaxOut = 2,
  parameter int CntW   = $clog2(MaxOut + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o,
  output logic            eligible_o
);

  localparam logic [CntW-1:0] MAX_CNT = CntW'(MaxOut);

  logic [CntW-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default assignment first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign eligible_o = req_i && (cnt_q < MAX_CNT);

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && (cnt_q == '0)));

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one dcache request port between the scalar load unit and the vector LSU.
// Define DCACHE_ARB_RR_EN for round-robin arbitration; otherwise scalar has fixed priority.
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int ReqW    = REQ_W,
  parameter int DataW   = 64,
  parameter int IdWidth = 1,
  parameter int MaxOut  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               s_req_i,
  output logic               s_gnt_o,
  input  logic [ReqW-1:0]    s_payload_i,
  input  logic [IdWidth-1:0] s_id_i,
  output logic               s_rvalid_o,
  output logic [IdWidth-1:0] s_rid_o,
  output logic [DataW-1:0]   s_rdata_o,
  input  logic               v_req_i,
  output logic               v_gnt_o,
  input  logic [ReqW-1:0]    v_payload_i,
  input  logic [IdWidth-1:0] v_id_i,
  output logic               v_rvalid_o,
  output logic [IdWidth-1:0] v_rid_o,
  output logic [DataW-1:0]   v_rdata_o,
  output logic               m_req_o,
  input  logic               m_gnt_i,
  output logic [ReqW-1:0]    m_payload_o,
  output logic [IdWidth:0]   m_id_o,
  input  logic               m_rvalid_i,
  input  logic [IdWidth:0]   m_rid_i,
  input  logic [DataW-1:0]   m_rdata_i,
  output logic               busy_o
);

  localparam int CntW = $clog2(MaxOut + 1);

  arb_state_e         state_q, state_d;
  logic               sel_valid, sel_owner, grant;
  logic               s_elig, v_elig, s_inc, v_inc, s_dec, v_dec;
  logic [CntW-1:0]    s_cnt, v_cnt;
  logic               rvalid_q, rvalid_d, rowner_q, rowner_d;
  logic [IdWidth-1:0] rid_q, rid_d;
  logic [DataW-1:0]   rdata_q, rdata_d;

`ifdef DCACHE_ARB_RR_EN
  logic rr_q, rr_d;
  assign rr_d = grant ? ~rr_q : rr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= OWNER_SCALAR;
    else       rr_q <= rr_d;
  end
`endif

  dcache_arb_out_cnt #(.MaxOut(MaxOut), .CntW(CntW)) u_s_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (s_req_i),
    .inc_i      (s_inc),
    .dec_i      (s_dec),
    .cnt_o      (s_cnt),
    .eligible_o (s_elig)
  );

  dcache_arb_out_cnt #(.MaxOut(MaxOut), .CntW(CntW)) u_v_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (v_req_i),
    .inc_i      (v_inc),
    .dec_i      (v_dec),
    .cnt_o      (v_cnt),
    .eligible_o (v_elig)
  );

  // A locked owner is driven unconditionally until the cache accepts it.
  always_comb begin
    sel_valid = 1'b0;
    sel_owner = OWNER_SCALAR;
    state_d   = state_q;
    unique case (state_q)
      IDLE: begin
        if (!flush_i && (s_elig || v_elig)) begin
          sel_valid = 1'b1;
          if (s_elig && v_elig) begin
`ifdef DCACHE_ARB_RR_EN
            sel_owner = rr_q;
`else
            sel_owner = OWNER_SCALAR;
`endif
          end else begin
            sel_owner = v_elig ? OWNER_VECTOR : OWNER_SCALAR;
          end
          if (!m_gnt_i) state_d = lock_state(sel_owner);
        end
      end
      LOCK_S: begin
        sel_valid = 1'b1;
        sel_owner = OWNER_SCALAR;
        if (m_gnt_i) state_d = IDLE;
      end
      LOCK_V: begin
        sel_valid = 1'b1;
        sel_owner = OWNER_VECTOR;
        if (m_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = sel_valid && m_gnt_i;
  assign s_inc = grant && (sel_owner == OWNER_SCALAR);
  assign v_inc = grant && (sel_owner == OWNER_VECTOR);
  assign s_dec = m_rvalid_i && (m_rid_i[IdWidth] == OWNER_SCALAR);
  assign v_dec = m_rvalid_i && (m_rid_i[IdWidth] == OWNER_VECTOR);

  assign m_req_o     = sel_valid;
  assign m_payload_o = (sel_owner == OWNER_VECTOR) ? v_payload_i : s_payload_i;
  assign m_id_o      = {sel_owner, (sel_owner == OWNER_VECTOR) ? v_id_i : s_id_i};
  assign s_gnt_o     = s_inc;
  assign v_gnt_o     = v_inc;

  always_comb begin
    rvalid_d = m_rvalid_i;
    rowner_d = rowner_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    if (m_rvalid_i) begin
      rowner_d = m_rid_i[IdWidth];
      rid_d    = m_rid_i[IdWidth-1:0];
      rdata_d  = m_rdata_i;
    end
  end

  // NOTE: the response data registers are reset as well so outputs never show X after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      rowner_q <= OWNER_SCALAR;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      rowner_q <= rowner_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign s_rvalid_o = rvalid_q && (rowner_q == OWNER_SCALAR);
  assign v_rvalid_o = rvalid_q && (rowner_q == OWNER_VECTOR);
  assign s_rid_o    = rid_q;
  assign v_rid_o    = rid_q;
  assign s_rdata_o  = rdata_q;
  assign v_rdata_o  = rdata_q;

  assign busy_o = (state_q != IDLE) || (s_cnt != '0) || (v_cnt != '0);

  a_lock_s_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == LOCK_S) |-> s_req_i);
  a_lock_v_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == LOCK_V) |-> v_req_i);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: directed scenarios plus a randomized phase against a queue-based model.
module tb_dcache_port_arbiter;
  import dcache_arb_pkg::*;

  localparam int ReqW    = REQ_W;
  localparam int DataW   = 64;
  localparam int IdWidth = 1;
  localparam int MaxOut  = 2;

  logic               clk_i = 1'b0;
  logic               rst_i, flush_i;
  logic               s_req_i, s_gnt_o, s_rvalid_o;
  logic [ReqW-1:0]    s_payload_i;
  logic [IdWidth-1:0] s_id_i, s_rid_o;
  logic [DataW-1:0]   s_rdata_o;
  logic               v_req_i, v_gnt_o, v_rvalid_o;
  logic [ReqW-1:0]    v_payload_i;
  logic [IdWidth-1:0] v_id_i, v_rid_o;
  logic [DataW-1:0]   v_rdata_o;
  logic               m_req_o, m_gnt_i, m_rvalid_i, busy_o;
  logic [ReqW-1:0]    m_payload_o;
  logic [IdWidth:0]   m_id_o, m_rid_i;
  logic [DataW-1:0]   m_rdata_i;

  dcache_port_arbiter #(.ReqW(ReqW), .DataW(DataW), .IdWidth(IdWidth), .MaxOut(MaxOut)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .s_req_i(s_req_i), .s_gnt_o(s_gnt_o), .s_payload_i(s_payload_i), .s_id_i(s_id_i),
    .s_rvalid_o(s_rvalid_o), .s_rid_o(s_rid_o), .s_rdata_o(s_rdata_o),
    .v_req_i(v_req_i), .v_gnt_o(v_gnt_o), .v_payload_i(v_payload_i), .v_id_i(v_id_i),
    .v_rvalid_o(v_rvalid_o), .v_rid_o(v_rid_o), .v_rdata_o(v_rdata_o),
    .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_payload_o(m_payload_o), .m_id_o(m_id_o),
    .m_rvalid_i(m_rvalid_i), .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding IDs per owner, the locked owner (-1 = none) and the RR pointer.
  logic [IdWidth-1:0] outq[2][$];
  int                 lock_own = -1;
  bit                 rr_m = 1'b0;
  bit                 rv_m = 1'b0, rown_m = 1'b0;
  logic [IdWidth-1:0] rid_m = '0;
  logic [DataW-1:0]   rdata_m = '0;
  bit                 model_ok = 1'b0;
  bit                 pend[2];
  int                 last_gnt = -1;
  logic [IdWidth-1:0] last_gnt_id = '0;
  bit                 e_act;
  int                 e_win;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ReqW-1:0] rand_payload();
    dcache_arb_req_t p;
    p.addr  = {$urandom, $urandom};
    p.be    = BE_W'($urandom);
    p.size  = SIZE_W'($urandom);
    p.wdata = {$urandom, $urandom};
    return p;
  endfunction

  task automatic predict();
    bit el0, el1;
    el0   = s_req_i && (outq[0].size() < MaxOut);
    el1   = v_req_i && (outq[1].size() < MaxOut);
    e_act = 1'b0;
    e_win = 0;
    if (lock_own >= 0) begin
      e_act = 1'b1;
      e_win = lock_own;
    end else if (!flush_i && (el0 || el1)) begin
      e_act = 1'b1;
      if (el0 && el1) begin
`ifdef DCACHE_ARB_RR_EN
        e_win = int'(rr_m);
`else
        e_win = 0;
`endif
      end else begin
        e_win = el1 ? 1 : 0;
      end
    end
  endtask

  task automatic compare();
    logic [IdWidth:0] exp_id;
    check("m_req", m_req_o, e_act);
    if (e_act) begin
      exp_id = {e_win[0], (e_win == 1) ? v_id_i : s_id_i};
      check("m_payload", m_payload_o, (e_win == 1) ? v_payload_i : s_payload_i);
      check("m_id", m_id_o, exp_id);
    end
    check("s_gnt", s_gnt_o, e_act && m_gnt_i && (e_win == 0));
    check("v_gnt", v_gnt_o, e_act && m_gnt_i && (e_win == 1));
    check("s_rvalid", s_rvalid_o, rv_m && !rown_m);
    check("v_rvalid", v_rvalid_o, rv_m && rown_m);
    if (rv_m) begin
      check("rid", rown_m ? v_rid_o : s_rid_o, rid_m);
      check("rdata", rown_m ? v_rdata_o : s_rdata_o, rdata_m);
    end
    check("busy", busy_o, (lock_own >= 0) || (outq[0].size() != 0) || (outq[1].size() != 0));
  endtask

  task automatic update();
    int own;
    if (rst_i) begin
      outq[0].delete();
      outq[1].delete();
      lock_own = -1;
      rr_m     = 1'b0;
      rv_m     = 1'b0;
      rown_m   = 1'b0;
      rid_m    = '0;
      rdata_m  = '0;
      pend[0]  = 1'b0;
      pend[1]  = 1'b0;
      last_gnt = -1;
      model_ok = 1'b1;
    end else begin
      last_gnt = -1;
      if (e_act && m_gnt_i) begin
        last_gnt_id = (e_win == 1) ? v_id_i : s_id_i;
        outq[e_win].push_back(last_gnt_id);
        rr_m        = ~rr_m;
        lock_own    = -1;
        pend[e_win] = 1'b0;
        last_gnt    = e_win;
      end else if (e_act) begin
        lock_own = e_win;
      end
      if (m_rvalid_i) begin
        own = int'(m_rid_i[IdWidth]);
        for (int k = 0; k < outq[own].size(); k++) begin
          if (outq[own][k] == m_rid_i[IdWidth-1:0]) begin
            outq[own].delete(k);
            break;
          end
        end
        rown_m  = m_rid_i[IdWidth];
        rid_m   = m_rid_i[IdWidth-1:0];
        rdata_m = m_rdata_i;
      end
      rv_m = m_rvalid_i;
    end
  endtask

  // Inputs are driven just after a falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic step();
    #1;
    predict();
    if (model_ok) compare();
    @(posedge clk_i);
    update();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    flush_i     = 1'b0;
    s_req_i     = 1'b0;
    v_req_i     = 1'b0;
    s_id_i      = '0;
    v_id_i      = '0;
    s_payload_i = rand_payload();
    v_payload_i = rand_payload();
    m_gnt_i     = 1'b0;
    m_rvalid_i  = 1'b0;
    m_rid_i     = '0;
    m_rdata_i   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

`ifdef DCACHE_ARB_RR_EN
  int fair_exp[4] = '{0, 1, 0, 1};
`else
  int fair_exp[4] = '{0, 0, 0, 0};
`endif

  initial begin
    logic [ReqW-1:0]    ps;
    logic [DataW-1:0]   d1;
    logic [IdWidth-1:0] vid;
    int                 o, idx;

    rst_i = 1'b1;
    idle_inputs();
    @(negedge clk_i);
    step();
    do_reset();

    // Reset state
    #1;
    check("rst_m_req", m_req_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_s_rvalid", s_rvalid_o, 1'b0);
    check("rst_v_rvalid", v_rvalid_o, 1'b0);
    step();

    // Single scalar request granted in the same cycle, then its response
    s_req_i = 1'b1; s_id_i = 1'b1; m_gnt_i = 1'b1;
    #1;
    check("t1_s_gnt", s_gnt_o, 1'b1);
    check("t1_m_id", m_id_o, 2'b01);
    step();
    d1 = {$urandom, $urandom};
    s_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rid_i = 2'b01; m_rdata_i = d1;
    step();
    m_rvalid_i = 1'b0;
    #1;
    check("t1_s_rvalid", s_rvalid_o, 1'b1);
    check("t1_s_rid", s_rid_o, 1'b1);
    check("t1_s_rdata", s_rdata_o, d1);
    check("t1_v_rvalid", v_rvalid_o, 1'b0);
    check("t1_busy", busy_o, 1'b0);
    step();

    // Lock hold: scalar wins after reset, vector payload changes must not leak through
    do_reset();
    ps = rand_payload();
    s_req_i = 1'b1; v_req_i = 1'b1; s_payload_i = ps; s_id_i = 1'b0; v_id_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lock_payload", m_payload_o, ps);
      check("lock_v_gnt", v_gnt_o, 1'b0);
      step();
      v_payload_i = rand_payload();
    end
    m_gnt_i = 1'b1;
    #1;
    check("lock_s_gnt", s_gnt_o, 1'b1);
    check("lock_v_gnt_late", v_gnt_o, 1'b0);
    step();
    s_req_i = 1'b0;
    #1;
    check("lock_loser_gnt", v_gnt_o, 1'b1);
    step();

    // Fairness with continuous requests; each previous grant is answered to keep counts low
    do_reset();
    s_req_i = 1'b1; v_req_i = 1'b1; m_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_rvalid_i = (last_gnt >= 0);
      m_rid_i    = {last_gnt[0], last_gnt_id};
      m_rdata_i  = {$urandom, $urandom};
      #1;
      check("fair_owner", {s_gnt_o, v_gnt_o}, (fair_exp[i] == 1) ? 2'b01 : 2'b10);
      step();
    end
    idle_inputs();

    // Outstanding limit on the vector requester
    do_reset();
    vid = 1'b1;
    v_req_i = 1'b1; v_id_i = vid; m_gnt_i = 1'b1;
    step();
    step();
    s_req_i = 1'b1;
    #1;
    check("lim_s_gnt", s_gnt_o, 1'b1);
    check("lim_v_gnt", v_gnt_o, 1'b0);
    step();
    s_req_i = 1'b0;
    #1;
    check("lim_m_req_off", m_req_o, 1'b0);
    step();
    m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rid_i = {1'b1, vid};
    #1;
    check("lim_m_req_rsp", m_req_o, 1'b0);
    step();
    m_rvalid_i = 1'b0; m_gnt_i = 1'b1;
    #1;
    check("lim_v_regrant", v_gnt_o, 1'b1);
    step();

    // Grant and response for the scalar in the same cycle, then flush behaviour
    do_reset();
    s_req_i = 1'b1; s_id_i = 1'b0; m_gnt_i = 1'b1;
    step();
    s_id_i = 1'b1; s_payload_i = rand_payload(); m_rvalid_i = 1'b1; m_rid_i = 2'b00;
    #1;
    check("sim_s_gnt", s_gnt_o, 1'b1);
    step();
    s_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
    #1;
    check("sim_busy_one", busy_o, 1'b1);
    step();
    m_rvalid_i = 1'b1; m_rid_i = 2'b01;
    step();
    m_rvalid_i = 1'b0;
    #1;
    check("sim_busy_zero", busy_o, 1'b0);
    step();
    s_req_i = 1'b1; flush_i = 1'b1; m_gnt_i = 1'b1;
    #1;
    check("flush_idle_m_req", m_req_o, 1'b0);
    check("flush_idle_s_gnt", s_gnt_o, 1'b0);
    step();
    flush_i = 1'b0; m_gnt_i = 1'b0;
    step();
    flush_i = 1'b1; m_gnt_i = 1'b1;
    #1;
    check("flush_lock_s_gnt", s_gnt_o, 1'b1);
    step();
    idle_inputs();

    // Reset while locked on the vector requester
    do_reset();
    v_req_i = 1'b1; m_gnt_i = 1'b1;
    step();
    m_gnt_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; v_req_i = 1'b0;
    #1;
    check("rstlock_busy", busy_o, 1'b0);
    check("rstlock_m_req", m_req_o, 1'b0);
    step();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!pend[0] && ($urandom % 3 != 0)) begin
        pend[0] = 1'b1; s_payload_i = rand_payload(); s_id_i = IdWidth'($urandom);
      end
      if (!pend[1] && ($urandom % 3 != 0)) begin
        pend[1] = 1'b1; v_payload_i = rand_payload(); v_id_i = IdWidth'($urandom);
      end
      s_req_i    = pend[0];
      v_req_i    = pend[1];
      flush_i    = ($urandom % 8 == 0);
      m_gnt_i    = $urandom % 2;
      m_rvalid_i = 1'b0;
      if ($urandom % 2 == 1) begin
        o = $urandom % 2;
        if (outq[o].size() == 0) o = 1 - o;
        if (outq[o].size() != 0) begin
          idx        = $urandom_range(0, outq[o].size() - 1);
          m_rvalid_i = 1'b1;
          m_rid_i    = {o[0], outq[o][idx]};
          m_rdata_i  = {$urandom, $urandom};
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
